// File: rtl/bram_stream_reader.sv
// Read-side controller for a single-port block RAM: issues a commanded span of
// reads, hides the RAM latency and presents the words as a valid/ready stream.
// Optional feature macro: BRAM_READER_CIRCULAR_EN (adds the `circular` input).
module bram_stream_reader #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  localparam int   AW              = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
`ifdef BRAM_READER_CIRCULAR_EN
  input  logic                 circular,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic                 ram_regcea,
  output logic [AW-1:0]        ram_addra,
  input  logic [RAM_WIDTH-1:0] ram_douta,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [1:0]           dbg_state
);

  localparam int          LAT       = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam logic [AW:0] DEPTH_L   = (AW+1)'(RAM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0] ONE_L     = (AW+1)'(1);

  // Handshake: a beat transfers on any rising edge where m_valid && m_ready;
  // m_data/m_last are held stable while m_valid is high and m_ready is low.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic [AW-1:0]          addr_q, base_q;
  logic [AW:0]            rem_q, len_q, len_clamped;
  logic [LAT-1:0]         lat_v, lat_last, lat_end;
  logic [2:0]             outstanding, fifo_count;
  logic [RAM_WIDTH-1:0]   fifo_data [4];
  logic [3:0]             fifo_last, fifo_end;
  logic [1:0]             wr_ptr, rd_ptr;
  logic                   accept, issue, final_issue, capture, pop, circ_now;

`ifdef BRAM_READER_CIRCULAR_EN
  assign circ_now = circular;
`else
  assign circ_now = 1'b0;
`endif

  assign len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
  assign accept      = (state_q == IDLE) && start && (len_clamped != '0);

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < LAT; i++) outstanding = outstanding + {2'b00, lat_v[i]};
  end

  // Credits count reads in flight plus words parked in the FIFO, so a capture
  // always finds a free slot.
  assign issue       = (state_q == RUN) && (rem_q != '0) && ((outstanding + fifo_count) < 3'd4);
  assign final_issue = issue && (rem_q == ONE_L);
  assign capture     = lat_v[LAT-1];
  assign m_valid     = (fifo_count != '0);
  assign pop         = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_clamped != '0) state_d = RUN;
          else                   done_d  = 1'b1;
        end
      end
      RUN: begin
        if (final_issue && !circ_now) state_d = DRAIN;
      end
      DRAIN: begin
        // Only the command-ending beat closes DRAIN; earlier pass-final beats
        // of a circular loop may still be draining here.
        if (pop && fifo_end[rd_ptr]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      lat_v    <= '0;
      lat_last <= '0;
      lat_end  <= '0;
    end else begin
      if (accept) begin
        addr_q <= base_addr;
        base_q <= base_addr;
        len_q  <= len_clamped;
        rem_q  <= len_clamped;
      end else if (issue) begin
        if (final_issue && circ_now) begin
          addr_q <= base_q;
          rem_q  <= len_q;
        end else begin
          addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
        end
      end
      lat_v[0]    <= issue;
      lat_last[0] <= final_issue;
      lat_end[0]  <= final_issue && !circ_now;
      for (int i = 1; i < LAT; i++) begin
        lat_v[i]    <= lat_v[i-1];
        lat_last[i] <= lat_last[i-1];
        lat_end[i]  <= lat_end[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      fifo_end   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) begin
        fifo_data[wr_ptr] <= ram_douta;
        fifo_last[wr_ptr] <= lat_last[LAT-1];
        fifo_end[wr_ptr]  <= lat_end[LAT-1];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_data     = fifo_data[rd_ptr];
  assign m_last     = m_valid && fifo_last[rd_ptr];
  assign ram_ena    = issue;
  assign ram_wea    = 1'b0;
  assign ram_addra  = addr_q;
  assign ram_regcea = (LAT == 2) ? lat_v[0] : 1'b0;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: behavioural RAM, span-level
// reference model and an in-order scoreboard of addresses, data and last flags.
module tb_bram_stream_reader;

  localparam int W     = 18;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
`ifdef BRAM_READER_CIRCULAR_EN
  logic          circular = 1'b0;
`endif
  logic          busy, done, ram_ena, ram_wea, ram_regcea;
  logic [AW-1:0] ram_addra;
  logic [W-1:0]  ram_douta, m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [1:0]    dbg_state;

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
`ifdef BRAM_READER_CIRCULAR_EN
    .circular(circular),
`endif
    .busy(busy), .done(done), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_regcea(ram_regcea),
    .ram_addra(ram_addra), .ram_douta(ram_douta), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural HIGH_PERFORMANCE RAM: array read then output register
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ram_q = '0;
  initial ram_douta = '0;
  always @(posedge clk) begin
    if (ram_ena) ram_q <= mem[ram_addra];
    if (ram_regcea) ram_douta <= ram_q;
  end

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic          exp_last_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int in_flight = 0;
  int issues = 0, pops = 0, done_cnt = 0;
  int first_issue = -1, first_valid = -1, last_pop_cyc = 0, done_cyc = 0;
  bit hold_v = 0;
  logic [W-1:0] hold_d;
  logic hold_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 0;
      hold_v = 0;
    end else begin
      if (ram_ena) begin
        check_eq("credit", in_flight <= 3, 1);
        check_eq("issue_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check_eq("ram_addra", ram_addra, exp_addr_q.pop_front());
        if (first_issue < 0) first_issue = cyc;
        issues++;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (hold_v) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, hold_d);
        check_eq("hold_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        check_eq("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check_eq("m_data", m_data, exp_q.pop_front());
          check_eq("m_last", m_last, exp_last_q.pop_front());
        end
        pops++;
        last_pop_cyc = cyc;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      in_flight = in_flight + int'(ram_ena) - int'(m_valid && m_ready);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  int ready_mode = 0;
  int rphase = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: begin
        m_ready = (rphase == 0) || (rphase == 3);
        rphase = (rphase + 1) % 4;
      end
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  end

  // reference model: a command reads min(len, DEPTH) consecutive wrapped words
  function automatic int clamp_len(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic model_cmd(input int base, input int len);
    int n;
    n = clamp_len(len);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'((base + i) % DEPTH));
      exp_q.push_back(mem[(base + i) % DEPTH]);
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ena", ram_ena, 0);
    check_eq("rst_wea", ram_wea, 0);
    check_eq("rst_regcea", ram_regcea, 0);
    check_eq("rst_addra", ram_addra, 0);
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_data", m_data, 0);
  endtask

  task automatic run_cmd(input int base, input int len, input bit poke);
    int n, d0, p0, e0, k, budget;
    n = clamp_len(len);
    model_cmd(base, len);
    first_issue = -1;
    first_valid = -1;
    d0 = done_cnt;
    p0 = pops;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    length = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    length = (AW+1)'($urandom);
    e0 = cyc;
    @(negedge clk); #1;
    if (n > 0) check_eq("busy_after_start", busy, 1);
    else begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
    end
    budget = 8 * n + 40;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
      if (poke && k == 6) begin
        start = 1'b1;
        base_addr = '0;
        length = 11'd7;
      end else start = 1'b0;
    end
    start = 1'b0;
    check_eq("done_timeout", done_cnt != d0, 1);
    check_eq("beats", pops - p0, n);
    check_eq("exp_left", exp_q.size(), 0);
    check_eq("addr_left", exp_addr_q.size(), 0);
    if (n > 0) begin
      check_eq("first_issue", first_issue, e0);
      check_eq("first_beat_lat", first_valid - first_issue, LAT + 1);
      check_eq("done_after_last", done_cyc, last_pop_cyc + 1);
    end else begin
      check_eq("zero_no_valid", first_valid, -1);
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq("done_once", done_cnt, d0 + 1);
    check_eq("idle_busy", busy, 0);
    check_eq("wea", ram_wea, 0);
  endtask

  task automatic reset_mid_stream();
    int p0, k;
    ready_mode = 0;
    model_cmd(40, 10);
    p0 = pops;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd40; length = 11'd10;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (pops - p0 < 3 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("pre_reset_beats", pops - p0, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmd(50, 2, 0);
  endtask

`ifdef BRAM_READER_CIRCULAR_EN
  task automatic circular_test();
    int d0, p0, i0, k;
    ready_mode = 0;
    for (int p = 0; p < 3; p++) model_cmd(700, 3);
    d0 = done_cnt; p0 = pops; i0 = issues;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd700; length = 11'd3; circular = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(negedge clk); #1;
      k++;
      if (issues - i0 >= 7) circular = 1'b0;
    end
    circular = 1'b0;
    check_eq("circ_done", done_cnt != d0, 1);
    check_eq("circ_beats", pops - p0, 9);
    check_eq("circ_exp_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("circ_done_once", done_cnt, d0 + 1);
  endtask
`endif

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = W'(a + 100);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    ready_mode = 0;
    run_cmd(5, 4, 0);
    run_cmd(1022, 4, 0);
    ready_mode = 1;
    run_cmd(200, 16, 0);
    ready_mode = 0;
    run_cmd(10, 0, 0);
    run_cmd(0, 2000, 0);
    run_cmd(300, 30, 1);
    reset_mid_stream();

    for (int a = 0; a < DEPTH; a++) mem[a] = W'($urandom);
    for (int t = 0; t < 12; t++) begin
      ready_mode = $urandom_range(0, 2);
      run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
    ready_mode = 2;
    run_cmd($urandom_range(900, DEPTH - 1), 1030, 0);

`ifdef BRAM_READER_CIRCULAR_EN
    circular_test();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
